// File: rtl/mem_stage_sequencer_if.sv
// mem_stage_sequencer_if: MEM-stage request bundle plus data-memory port.
// The slave side is the sequencer; the master side is pipeline and memory.
interface mem_stage_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                    req_valid;
  logic [3:0]              opcode;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   store_data;
  logic                    mem_resp;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic [ADDR_WIDTH-1:0]   mem_address;
  logic                    mem_read;
  logic                    mem_write;
  logic [DATA_WIDTH/8-1:0] mem_byte_enable;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   load_data;
  logic                    done;
  logic                    stall;
  logic                    err;

  modport slave (
    input  req_valid, opcode, addr, store_data,
    input  mem_resp, mem_rdata,
    output mem_address, mem_read, mem_write,
    output mem_byte_enable, mem_wdata,
    output load_data, done, stall, err
  );

  modport master (
    output req_valid, opcode, addr, store_data,
    output mem_resp, mem_rdata,
    input  mem_address, mem_read, mem_write,
    input  mem_byte_enable, mem_wdata,
    input  load_data, done, stall, err
  );
endinterface

// File: rtl/mem_stage_sequencer.sv
// mem_stage_sequencer: LC-3b MEM-stage access sequencer with byte-lane
// steering, two-phase indirect LDI/STI, stall/done and response timeout.
module mem_stage_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int WAIT_LIMIT = 64
) (
  input logic clk,
  input logic reset,
  mem_stage_sequencer_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int L  = $clog2(NB);
  localparam int LW = (L > 0) ? L : 1;
  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  localparam logic [CW-1:0] CNT_LAST =
    CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK =
    ADDR_WIDTH'(NB - 1);

  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_IND,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              op_q, op_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   sdata_q, sdata_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   ld_q, ld_d;
  logic                    err_q, err_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0]   maddr_c;
  logic                    rd_c;
  logic                    wr_c;
  logic [NB-1:0]           be_c;
  logic [DATA_WIDTH-1:0]   wdata_c;
  logic                    done_c;
  logic                    stall_c;

  logic                    accept;
  logic                    is_ind;
  logic                    is_st;
  logic                    is_byte;
  logic                    tmo;
  logic [LW-1:0]           lane;
  logic [NB-1:0]           be_lane;
  logic [7:0]              byte_c;
  logic [ADDR_WIDTH-1:0]   eff_addr;
  logic [CW-1:0]           cnt_inc;

  function automatic logic [ADDR_WIDTH-1:0] word_of(
    input logic [ADDR_WIDTH-1:0] a
  );
    return a & ~LANE_MASK;
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDB) || (op == OP_STB) ||
           (op == OP_LDR) || (op == OP_STR) ||
           (op == OP_LDI) || (op == OP_STI);
  endfunction

  assign accept   = bus.req_valid && is_mem_op(bus.opcode);
  assign is_ind   = (op_q == OP_LDI) || (op_q == OP_STI);
  assign is_st    = op_q[0];
  assign is_byte  = (op_q == OP_LDB) || (op_q == OP_STB);
  assign tmo      = (WAIT_LIMIT != 0) && (cnt_q == CNT_LAST);
  assign lane     = LW'(addr_q & LANE_MASK);
  assign be_lane  = NB'(1) << lane;
  assign byte_c   = 8'(bus.mem_rdata >> {lane, 3'b000});
  assign eff_addr = is_ind ? ptr_q : addr_q;
  assign cnt_inc  = (WAIT_LIMIT != 0) ? cnt_q + 1'b1 : cnt_q;

  // Next-state, datapath capture and memory-port outputs
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    ptr_d   = ptr_q;
    ld_d    = ld_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    maddr_c = '0;
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    be_c    = '0;
    wdata_c = '0;
    done_c  = 1'b0;
    stall_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          stall_c = 1'b1;
          op_d    = bus.opcode;
          addr_d  = bus.addr;
          sdata_d = bus.store_data;
          cnt_d   = '0;
          if ((bus.opcode == OP_LDI) ||
              (bus.opcode == OP_STI)) begin
            state_d = S_IND;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_IND: begin
        stall_c = 1'b1;
        rd_c    = 1'b1;
        maddr_c = word_of(addr_q);
        be_c    = '1;
        if (bus.mem_resp) begin
          ptr_d   = ADDR_WIDTH'(bus.mem_rdata);
          cnt_d   = '0;
          state_d = S_ACCESS;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ACCESS: begin
        stall_c = 1'b1;
        rd_c    = !is_st;
        wr_c    = is_st;
        if (is_byte) begin
          maddr_c = eff_addr;
          be_c    = be_lane;
          wdata_c = {NB{sdata_q[7:0]}};
        end else begin
          maddr_c = word_of(eff_addr);
          be_c    = '1;
          wdata_c = sdata_q;
        end
        if (bus.mem_resp) begin
          if (!is_st) begin
            ld_d = is_byte ? DATA_WIDTH'(byte_c)
                           : bus.mem_rdata;
          end
          state_d = S_DONE;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any request at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      ptr_q   <= '0;
      ld_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      ptr_q   <= ptr_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mem_address     = maddr_c;
  assign bus.mem_read        = rd_c;
  assign bus.mem_write       = wr_c;
  assign bus.mem_byte_enable = be_c;
  assign bus.mem_wdata       = wdata_c;
  assign bus.load_data       = ld_q;
  assign bus.done            = done_c;
  assign bus.stall           = stall_c;
  assign bus.err             = err_q;
endmodule
